// File: rtl/bsg_link_credit_arbiter_if.sv
// Requester, link and status signals shared by the credit arbiter and its environment.
// The slave modport is the arbiter's view; master is the driving environment.
interface bsg_link_credit_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int CREDITS = 16
);
    localparam int CW = $clog2(CREDITS + 1);
    localparam int GW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid_i;
    logic [NUM_REQ-1:0]       req_last_i;
    logic [NUM_REQ*WIDTH-1:0] req_data_i;
    logic [NUM_REQ-1:0]       req_yumi_o;
    logic                     link_valid_o;
    logic [WIDTH-1:0]         link_data_o;
    logic                     link_ready_i;
    logic                     token_i;
    logic [CW-1:0]            credit_o;
    logic [GW-1:0]            grant_o;
    logic                     busy_o;
    logic                     overflow_o;

    modport master (
        output req_valid_i, req_last_i, req_data_i, link_ready_i, token_i,
        input  req_yumi_o, link_valid_o, link_data_o, credit_o, grant_o, busy_o, overflow_o
    );

    modport slave (
        input  req_valid_i, req_last_i, req_data_i, link_ready_i, token_i,
        output req_yumi_o, link_valid_o, link_data_o, credit_o, grant_o, busy_o, overflow_o
    );
endinterface

// File: rtl/bsg_link_credit_arbiter.sv
// Credit-gated round-robin packet arbiter feeding one registered link flit slot; 1 cycle req->link.
// Holds the flit while link_ready_i is low and stops consuming when credits reach zero.
module bsg_link_credit_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int WIDTH    = 16,
    parameter int CREDITS  = 16,
    parameter int LG_DECIM = 2
) (
    input logic                      clk_i,
    input logic                      reset_n_i,
    bsg_link_credit_arbiter_if.slave bus
);
    localparam int CW = $clog2(CREDITS + 1);
    localparam int GW = $clog2(NUM_REQ);
    localparam logic [CW:0] MAX_CRED  = (CW+1)'(CREDITS);
    localparam logic [CW:0] TOKEN_INC = (CW+1)'(2**LG_DECIM);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [GW-1:0]    grant_q;
    logic [GW-1:0]    sel;
    logic [GW-1:0]    cand;
    logic             found;
    logic             sel_valid;
    logic             sel_last;
    logic [WIDTH-1:0] sel_data;
    logic             slot_free;
    logic             load;
    logic             link_valid_q;
    logic [WIDTH-1:0] link_data_q;
    logic [CW-1:0]    credit_q;
    logic             overflow_q;
    logic [CW:0]      credit_sum;

    // Round-robin search starts just after the last owner; a packet in flight pins sel.
    always_comb begin
        sel   = grant_q;
        cand  = grant_q;
        found = 1'b0;
        if (state_q == IDLE) begin
            for (int i = 1; i <= NUM_REQ; i++) begin
                cand = GW'((int'(grant_q) + i) % NUM_REQ);
                if (!found && bus.req_valid_i[cand]) begin
                    found = 1'b1;
                    sel   = cand;
                end
            end
        end
    end

    assign sel_valid = bus.req_valid_i[sel];
    assign sel_last  = bus.req_last_i[sel];
    assign sel_data  = bus.req_data_i[int'(sel)*WIDTH +: WIDTH];
    assign slot_free = ~link_valid_q | bus.link_ready_i;
    assign load      = reset_n_i & slot_free & (credit_q != '0) & sel_valid;

    always_comb begin
        bus.req_yumi_o = '0;
        if (load) begin
            bus.req_yumi_o[sel] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load && !sel_last) state_d = BUSY;
            BUSY:    if (load &&  sel_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // One bit of headroom so a token arriving near the cap is detected, not wrapped.
    assign credit_sum = {1'b0, credit_q} - {{CW{1'b0}}, load} + (bus.token_i ? TOKEN_INC : '0);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            grant_q      <= GW'(NUM_REQ - 1);
            link_valid_q <= 1'b0;
            link_data_q  <= '0;
            credit_q     <= CW'(CREDITS);
            overflow_q   <= 1'b0;
        end else begin
            if (load) begin
                grant_q      <= sel;
                link_valid_q <= 1'b1;
                link_data_q  <= sel_data;
            end else if (slot_free) begin
                link_valid_q <= 1'b0;
            end
            if (credit_sum > MAX_CRED) begin
                credit_q   <= CW'(CREDITS);
                overflow_q <= 1'b1;
            end else begin
                credit_q   <= credit_sum[CW-1:0];
            end
        end
    end

    assign bus.link_valid_o = link_valid_q;
    assign bus.link_data_o  = link_data_q;
    assign bus.credit_o     = credit_q;
    assign bus.grant_o      = grant_q;
    assign bus.busy_o       = (state_q == BUSY);
    assign bus.overflow_o   = overflow_q;
endmodule

// File: tb/tb_bsg_link_credit_arbiter.sv
module tb_bsg_link_credit_arbiter;
    localparam int NR  = 4;
    localparam int W   = 16;
    localparam int CR  = 16;
    localparam int LD  = 2;
    localparam int INC = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bsg_link_credit_arbiter_if #(.NUM_REQ(NR), .WIDTH(W), .CREDITS(CR)) bus ();

    bsg_link_credit_arbiter #(.NUM_REQ(NR), .WIDTH(W), .CREDITS(CR), .LG_DECIM(LD)) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: credits, last owner, packet lock, output slot.
    int          m_credit;
    int          m_ptr;
    bit          m_locked;
    bit          m_vld;
    bit          m_ovf;
    logic [W-1:0] m_dat;

    int           n_yumi;
    int           n_busy;
    logic [NR-1:0] last_yumi;
    int           c0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_credit = CR;
        m_ptr    = NR - 1;
        m_locked = 1'b0;
        m_vld    = 1'b0;
        m_dat    = '0;
        m_ovf    = 1'b0;
    endtask

    task automatic drive(input logic [NR-1:0] v, input logic [NR-1:0] l, input bit rdy, input bit tok);
        bus.req_valid_i  = v;
        bus.req_last_i   = l;
        bus.link_ready_i = rdy;
        bus.token_i      = tok;
    endtask

    task automatic set_data(input int r, input logic [W-1:0] d);
        bus.req_data_i[r*W +: W] = d;
    endtask

    // One clock: compare at negedge against the reference, then advance the reference.
    task automatic cycle();
        int            c;
        bit            sf;
        bit            go;
        logic [NR-1:0] exp_yumi;
        @(negedge clk);
        sf = !m_vld || bus.link_ready_i;
        c  = -1;
        if (m_locked) begin
            if (bus.req_valid_i[m_ptr]) c = m_ptr;
        end else begin
            for (int k = 1; k <= NR; k++)
                if (c < 0 && bus.req_valid_i[(m_ptr + k) % NR]) c = (m_ptr + k) % NR;
        end
        go       = sf && (m_credit > 0) && (c >= 0);
        exp_yumi = go ? NR'(1 << c) : '0;
        check("yumi",       32'(bus.req_yumi_o), 32'(exp_yumi));
        check("link_valid", 32'(bus.link_valid_o), 32'(m_vld));
        check("link_data",  32'(bus.link_data_o), 32'(m_dat));
        check("credit",     32'(bus.credit_o), 32'(m_credit));
        check("grant",      32'(bus.grant_o), 32'(m_ptr));
        check("busy",       32'(bus.busy_o), 32'(m_locked));
        check("overflow",   32'(bus.overflow_o), 32'(m_ovf));
        last_yumi = bus.req_yumi_o;
        if (bus.req_yumi_o != '0) n_yumi++;
        if (bus.busy_o) n_busy++;
        @(posedge clk);
        if (go) begin
            m_vld    = 1'b1;
            m_dat    = bus.req_data_i[c*W +: W];
            m_ptr    = c;
            m_locked = !bus.req_last_i[c];
        end else if (sf) begin
            m_vld = 1'b0;
        end
        m_credit = m_credit - (go ? 1 : 0) + (bus.token_i ? INC : 0);
        if (m_credit > CR) begin
            m_credit = CR;
            m_ovf    = 1'b1;
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        drive('0, '0, 1'b1, 1'b0);
        bus.req_data_i = '0;
        model_reset();

        // Reset values, held in reset and after release
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_credit", 32'(bus.credit_o), 32'd16);
        check("rst_hold_valid",  32'(bus.link_valid_o), 32'd0);
        rst_n = 1'b1;
        check("rst_credit",   32'(bus.credit_o), 32'd16);
        check("rst_valid",    32'(bus.link_valid_o), 32'd0);
        check("rst_grant",    32'(bus.grant_o), 32'd3);
        check("rst_busy",     32'(bus.busy_o), 32'd0);
        check("rst_overflow", 32'(bus.overflow_o), 32'd0);
        cycle();

        // Credit exhaustion: single-flit stream from req0, no tokens
        n_yumi = 0;
        for (int i = 0; i < 20; i++) begin
            set_data(0, 16'h0100 + 16'(i));
            drive(4'b0001, 4'b1111, 1'b1, 1'b0);
            cycle();
        end
        check("exh_yumis",  32'(n_yumi), 32'd16);
        check("exh_credit", 32'(bus.credit_o), 32'd0);
        check("exh_valid",  32'(bus.link_valid_o), 32'd0);
        n_yumi = 0;
        drive(4'b0001, 4'b1111, 1'b1, 1'b1);
        cycle();
        check("tok_same_cycle_yumis", 32'(n_yumi), 32'd0);
        drive(4'b0001, 4'b1111, 1'b1, 1'b0);
        repeat (8) cycle();
        check("tok_yumis", 32'(n_yumi), 32'd4);

        // Refill to 12
        drive('0, '0, 1'b1, 1'b1);
        repeat (3) cycle();
        drive('0, '0, 1'b1, 1'b0);
        cycle();
        check("refill_credit", 32'(bus.credit_o), 32'd12);

        // Round robin, token every fourth cycle keeps credit balanced
        for (int i = 0; i < 12; i++) begin
            for (int r = 0; r < NR; r++) set_data(r, 16'(r * 256 + i));
            drive(4'b1111, 4'b1111, 1'b1, (i % 4) == 3);
            cycle();
            check("rr_yumi", 32'(last_yumi), 32'(1 << ((1 + i) % 4)));
        end
        check("rr_grant_end", 32'(bus.grant_o), 32'd0);

        // Packet lock: req1 3-flit packet with req2 waiting
        drive('0, '0, 1'b1, 1'b0);
        cycle();
        n_busy = 0;
        set_data(2, 16'h2222);
        set_data(1, 16'h1001);
        drive(4'b0110, 4'b0100, 1'b1, 1'b0);
        cycle();
        check("lock_f1", 32'(last_yumi), 32'h2);
        set_data(1, 16'h1002);
        cycle();
        check("lock_f2", 32'(last_yumi), 32'h2);
        set_data(1, 16'h1003);
        drive(4'b0110, 4'b0110, 1'b1, 1'b0);
        cycle();
        check("lock_f3", 32'(last_yumi), 32'h2);
        cycle();
        check("lock_req2", 32'(last_yumi), 32'h4);
        check("lock_busy_cycles", 32'(n_busy), 32'd2);
        drive('0, '0, 1'b1, 1'b0);
        cycle();

        // Backpressure with 0xA5A5 pending
        set_data(0, 16'hA5A5);
        drive(4'b0001, 4'b0001, 1'b0, 1'b0);
        cycle();
        set_data(0, 16'h1234);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("bp_data",   32'(bus.link_data_o), 32'hA5A5);
            check("bp_yumi",   32'(last_yumi), 32'd0);
            check("bp_credit", 32'(bus.credit_o), 32'd7);
        end
        drive(4'b0001, 4'b0001, 1'b1, 1'b0);
        cycle();
        check("bp_release_yumi", 32'(last_yumi), 32'h1);
        check("bp_release_data", 32'(bus.link_data_o), 32'h1234);

        // Overflow: steer credit to 14, then one token
        check("pre_overflow", 32'(bus.overflow_o), 32'd0);
        for (int k = 0; k < 40 && m_credit != 14; k++) begin
            if (m_credit > 10) drive(4'b0001, 4'b0001, 1'b1, 1'b0);
            else               drive('0, '0, 1'b1, 1'b1);
            cycle();
        end
        drive('0, '0, 1'b1, 1'b0);
        cycle();
        check("ovf_pre_credit", 32'(bus.credit_o), 32'd14);
        drive('0, '0, 1'b1, 1'b1);
        cycle();
        check("ovf_credit", 32'(bus.credit_o), 32'd16);
        check("ovf_flag",   32'(bus.overflow_o), 32'd1);
        drive('0, '0, 1'b1, 1'b0);
        repeat (3) cycle();
        check("ovf_sticky", 32'(bus.overflow_o), 32'd1);

        // Randomized traffic against the reference
        for (int i = 0; i < 300; i++) begin
            for (int r = 0; r < NR; r++) set_data(r, 16'($urandom));
            drive(NR'($urandom), NR'($urandom), $urandom_range(3) != 0, $urandom_range(4) == 0);
            cycle();
        end

        // Asynchronous reset in the middle of a cycle
        drive(4'b1111, 4'b0000, 1'b1, 1'b0);
        repeat (2) cycle();
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid",    32'(bus.link_valid_o), 32'd0);
        check("arst_credit",   32'(bus.credit_o), 32'd16);
        check("arst_grant",    32'(bus.grant_o), 32'd3);
        check("arst_busy",     32'(bus.busy_o), 32'd0);
        check("arst_overflow", 32'(bus.overflow_o), 32'd0);
        check("arst_yumi",     32'(bus.req_yumi_o), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        drive(4'b0100, 4'b0100, 1'b1, 1'b0);
        repeat (3) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
